dmem_access_ctrl: RTL and testbench
===================================

// Module: dmem_access_ctrl
// PURPOSE
//  Sequences each data-memory access in the MEM stage of the 8-bit pipelined CPU.
//  - Computes the store-data forwarding select that drives the store-data mux (0 = EX/MEM data, 1 = WB data).
//  - Latches the selected store data at access start.
//  - Runs a fixed-latency access with wait states and stalls the pipeline until the access completes.
//  - Keeps a sticky protocol-error flag and a saturating stall-cycle counter.
// PARAMETERS
//  DW      8  data width of store data
//  REG_AW  3  register-file address width
//  MEM_LAT 1  data-memory access latency in cycles; legal range 1..15
// PORTS
//  clk             in   1       rising-edge clock
//  reset           in   1       async, active-high reset
//  exmem_valid     in   1       EX/MEM holds a live instruction
//  exmem_mem_read  in   1       load in MEM stage
//  exmem_mem_write in   1       store in MEM stage
//  exmem_rs        in   REG_AW  register that sources the store data
//  memwb_reg_write in   1       WB-stage instruction writes the register file
//  memwb_rd        in   REG_AW  WB destination register
//  mux_data        in   DW      output of the store-data mux
//  fwd_sel         out  1       select for the store-data mux
//  dmem_en         out  1       memory enable
//  dmem_we         out  1       memory write enable
//  dmem_wdata      out  DW      store data to memory
//  pipe_stall      out  1       freeze IF..MEM this cycle
//  load_done       out  1       1-cycle pulse: load data valid this cycle
//  proto_err       out  1       sticky: read and write both requested
//  stall_count     out  16      saturating count of stall cycles
// BEHAVIOUR
//  Reset: FSM to IDLE; all registers clear; every output 0; an access in progress is abandoned.
//  req = exmem_valid & (exmem_mem_read ^ exmem_mem_write).
//  Read and write both high with exmem_valid:
//    - Treated as a NOP: no enable, no stall.
//    - proto_err sets on the next edge and stays set until reset.
//  fwd_sel (combinational in IDLE) = exmem_mem_write & memwb_reg_write & (memwb_rd == exmem_rs).
//    - No register-0 exception.
//    - Outside IDLE, fwd_sel = fwd_q, the value latched at access start.
//  Cycle 0 of an access is the IDLE cycle in which req=1:
//    - dmem_en = 1; dmem_we = exmem_mem_write.
//    - dmem_wdata = mux_data.
//    - wdata_q <= mux_data; fwd_q <= fwd_sel; we_q <= exmem_mem_write.
//  MEM_LAT == 1:
//    - Stays in IDLE; pipe_stall = 0.
//    - load_done = exmem_mem_read in cycle 0.
//  MEM_LAT > 1, FSM IDLE -> WAIT -> LAST -> IDLE:
//    - cnt loads MEM_LAT-2 in cycle 0.
//    - WAIT decrements cnt; WAIT -> LAST when cnt == 0. MEM_LAT == 2 goes IDLE -> LAST directly.
//    - pipe_stall = 1 in cycles 0..MEM_LAT-2 and 0 in LAST.
//    - dmem_en = 1 in all MEM_LAT cycles.
//    - dmem_we = we_q and dmem_wdata = wdata_q after cycle 0.
//    - load_done pulses in LAST for a load.
//  LAST -> IDLE unconditionally. The instruction that enters MEM on that edge is evaluated in IDLE,
//    so back-to-back accesses have zero bubble cycles.
//  Stall hold: inputs may change during WAIT/LAST (WB retires while stalled).
//    dmem_we/dmem_wdata/fwd_sel depend only on latched state there.
//  Idle: dmem_en = dmem_we = 0 when IDLE and req = 0; dmem_wdata = 0 when dmem_en = 0.
//  stall_count increments each cycle pipe_stall = 1 and saturates at 16'hFFFF.
// STRUCTURE
//  Package dmem_ctrl_pkg holds:
//    - typedef enum logic [1:0] {IDLE, WAIT, LAST} dmem_state_t
//    - localparam CNT_W = 4
//    - localparam STALL_CNT_MAX = 16'hFFFF
//  One sub-module, dmem_wait_counter:
//    - Loadable down-counter with a zero flag.
//    - Ports: clk, reset, load, load_val, dec, zero.
//  FSM, forwarding compare, data latch and stall counter stay in dmem_access_ctrl.
// TESTING
//  1. MEM_LAT=1, store with exmem_rs=3, memwb_rd=3, memwb_reg_write=1, mux_data=8'hA5
//     -> fwd_sel=1, dmem_en=dmem_we=1, dmem_wdata=A5, pipe_stall=0.
//  2. MEM_LAT=3, store with mux_data=8'h3C; mux_data changes to 8'h00 and memwb_reg_write drops in cycle 1
//     -> dmem_wdata=3C and fwd_sel held for 3 cycles; pipe_stall=1,1,0; stall_count=2.
//  3. MEM_LAT=3, load then store back-to-back
//     -> load_done pulses in cycle 2; store's cycle 0 is cycle 3; no idle cycle between accesses.
//  4. exmem_valid=1 with mem_read=mem_write=1
//     -> dmem_en=0, pipe_stall=0, proto_err=1 next cycle and held over 10 later legal accesses.
//  5. MEM_LAT=4, reset asserted in WAIT
//     -> all outputs 0 immediately; after release, a new load completes normally with load_done in cycle 3.
//  6. Force 70000 stall cycles -> stall_count=16'hFFFF with no wrap.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data-memory access controller.
package dmem_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, LAST} dmem_state_t;
  localparam int CNT_W = 4;
  localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;
endpackage

// File: rtl/dmem_wait_counter.sv
// Loadable down-counter tracking the remaining wait-state cycles of an access.
module dmem_wait_counter
  import dmem_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // While decrementing, zero flags the count that this cycle's decrement exhausts.
  assign zero = dec ? (cnt == CNT_W'(1)) : (cnt == '0);

endmodule

// File: rtl/dmem_access_ctrl.sv
// Sequences one fixed-latency data-memory access per MEM-stage instruction,
// stalling the pipeline through the wait states and holding store data/forwarding.
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int DW      = 8,
  parameter int REG_AW  = 3,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exmem_valid,
  input  logic              exmem_mem_read,
  input  logic              exmem_mem_write,
  input  logic [REG_AW-1:0] exmem_rs,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DW-1:0]     mux_data,
  output logic              fwd_sel,
  output logic              dmem_en,
  output logic              dmem_we,
  output logic [DW-1:0]     dmem_wdata,
  output logic              pipe_stall,
  output logic              load_done,
  output logic              proto_err,
  output logic [15:0]       stall_count,
  output dmem_state_t       state
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);

  dmem_state_t   state_q, state_next;
  logic          req, conflict, fwd_now;
  logic          cnt_load, cnt_dec, cnt_zero;
  logic          fwd_q, we_q;
  logic [DW-1:0] wdata_q;
  logic          fwd_c, en_c, we_c, stall_c, done_c;
  logic [DW-1:0] wdata_c;

  assign req      = exmem_valid & (exmem_mem_read ^ exmem_mem_write);
  assign conflict = exmem_valid & exmem_mem_read & exmem_mem_write;
  assign fwd_now  = exmem_mem_write & memwb_reg_write & (memwb_rd == exmem_rs);

  dmem_wait_counter u_wait_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (LOAD_VAL),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  always_comb begin
    state_next = state_q;
    fwd_c      = 1'b0;
    en_c       = 1'b0;
    we_c       = 1'b0;
    wdata_c    = '0;
    stall_c    = 1'b0;
    done_c     = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    case (state_q)
      IDLE: begin
        fwd_c = fwd_now;
        if (req) begin
          en_c     = 1'b1;
          we_c     = exmem_mem_write;
          wdata_c  = mux_data;
          cnt_load = 1'b1;
          if (MEM_LAT == 1) begin
            done_c = exmem_mem_read;
          end else begin
            stall_c    = 1'b1;
            state_next = (MEM_LAT == 2) ? LAST : WAIT;
          end
        end
      end
      WAIT: begin
        fwd_c   = fwd_q;
        en_c    = 1'b1;
        we_c    = we_q;
        wdata_c = wdata_q;
        stall_c = 1'b1;
        cnt_dec = 1'b1;
        if (cnt_zero) state_next = LAST;
      end
      LAST: begin
        fwd_c      = fwd_q;
        en_c       = 1'b1;
        we_c       = we_q;
        wdata_c    = wdata_q;
        done_c     = ~we_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are forced low while reset is held, even if a request is still presented.
  assign fwd_sel    = fwd_c & ~reset;
  assign dmem_en    = en_c & ~reset;
  assign dmem_we    = we_c & ~reset;
  assign dmem_wdata = reset ? '0 : wdata_c;
  assign pipe_stall = stall_c & ~reset;
  assign load_done  = done_c & ~reset;
  assign state      = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdata_q     <= '0;
      fwd_q       <= 1'b0;
      we_q        <= 1'b0;
      proto_err   <= 1'b0;
      stall_count <= '0;
    end else begin
      if ((state_q == IDLE) && req) begin
        wdata_q <= mux_data;
        fwd_q   <= fwd_now;
        we_q    <= exmem_mem_write;
      end
      if (conflict) proto_err <= 1'b1;
      if (stall_c && (stall_count != STALL_CNT_MAX)) stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: four latencies driven in parallel from shared inputs,
// each checked against an access-position reference model.
module tb_dmem_access_ctrl;
  import dmem_ctrl_pkg::*;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0, reg_write = 1'b0;
  logic [2:0] rs = '0, wb_rd = '0;
  logic [7:0] mux = '0;

  logic        fwd_o[N], en_o[N], we_o[N], stall_o[N], ld_o[N], err_o[N];
  logic [7:0]  wd_o[N];
  logic [15:0] sc_o[N];
  dmem_state_t st_o[N];

  int lat[N] = '{1, 3, 4, 15};
  int tests = 0;
  int fails = 0;

  // Reference model: position within the current access (0 = not busy) plus latched fields.
  int         pos[N];
  int         m_sc[N];
  logic       m_we[N], m_fwd[N], m_err[N];
  logic [7:0] m_wd[N];
  logic       e_stall[N];

  always #5 clk = ~clk;

  dmem_access_ctrl #(.DW(8), .REG_AW(3), .MEM_LAT(1)) u_l1 (
    .clk(clk), .reset(reset), .exmem_valid(valid), .exmem_mem_read(mem_read),
    .exmem_mem_write(mem_write), .exmem_rs(rs), .memwb_reg_write(reg_write), .memwb_rd(wb_rd),
    .mux_data(mux), .fwd_sel(fwd_o[0]), .dmem_en(en_o[0]), .dmem_we(we_o[0]),
    .dmem_wdata(wd_o[0]), .pipe_stall(stall_o[0]), .load_done(ld_o[0]), .proto_err(err_o[0]),
    .stall_count(sc_o[0]), .state(st_o[0]));
  dmem_access_ctrl #(.DW(8), .REG_AW(3), .MEM_LAT(3)) u_l3 (
    .clk(clk), .reset(reset), .exmem_valid(valid), .exmem_mem_read(mem_read),
    .exmem_mem_write(mem_write), .exmem_rs(rs), .memwb_reg_write(reg_write), .memwb_rd(wb_rd),
    .mux_data(mux), .fwd_sel(fwd_o[1]), .dmem_en(en_o[1]), .dmem_we(we_o[1]),
    .dmem_wdata(wd_o[1]), .pipe_stall(stall_o[1]), .load_done(ld_o[1]), .proto_err(err_o[1]),
    .stall_count(sc_o[1]), .state(st_o[1]));
  dmem_access_ctrl #(.DW(8), .REG_AW(3), .MEM_LAT(4)) u_l4 (
    .clk(clk), .reset(reset), .exmem_valid(valid), .exmem_mem_read(mem_read),
    .exmem_mem_write(mem_write), .exmem_rs(rs), .memwb_reg_write(reg_write), .memwb_rd(wb_rd),
    .mux_data(mux), .fwd_sel(fwd_o[2]), .dmem_en(en_o[2]), .dmem_we(we_o[2]),
    .dmem_wdata(wd_o[2]), .pipe_stall(stall_o[2]), .load_done(ld_o[2]), .proto_err(err_o[2]),
    .stall_count(sc_o[2]), .state(st_o[2]));
  dmem_access_ctrl #(.DW(8), .REG_AW(3), .MEM_LAT(15)) u_l15 (
    .clk(clk), .reset(reset), .exmem_valid(valid), .exmem_mem_read(mem_read),
    .exmem_mem_write(mem_write), .exmem_rs(rs), .memwb_reg_write(reg_write), .memwb_rd(wb_rd),
    .mux_data(mux), .fwd_sel(fwd_o[3]), .dmem_en(en_o[3]), .dmem_we(we_o[3]),
    .dmem_wdata(wd_o[3]), .pipe_stall(stall_o[3]), .load_done(ld_o[3]), .proto_err(err_o[3]),
    .stall_count(sc_o[3]), .state(st_o[3]));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      pos[i] = 0; m_sc[i] = 0; m_we[i] = 1'b0; m_fwd[i] = 1'b0; m_err[i] = 1'b0; m_wd[i] = '0;
      e_stall[i] = 1'b0;
    end
  endtask

  // Called just after a falling edge; checks outputs with the request still applied.
  task automatic reset_all();
    reset = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst_en[L%0d]", lat[i]), 16'(en_o[i]), 16'd0);
      chk($sformatf("rst_we[L%0d]", lat[i]), 16'(we_o[i]), 16'd0);
      chk($sformatf("rst_wd[L%0d]", lat[i]), 16'(wd_o[i]), 16'd0);
      chk($sformatf("rst_fwd[L%0d]", lat[i]), 16'(fwd_o[i]), 16'd0);
      chk($sformatf("rst_stall[L%0d]", lat[i]), 16'(stall_o[i]), 16'd0);
      chk($sformatf("rst_ld[L%0d]", lat[i]), 16'(ld_o[i]), 16'd0);
      chk($sformatf("rst_err[L%0d]", lat[i]), 16'(err_o[i]), 16'd0);
      chk($sformatf("rst_sc[L%0d]", lat[i]), sc_o[i], 16'd0);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic settle_check(input bit do_chk);
    logic req, fc, e_en, e_we, e_fwd, e_ld;
    logic [7:0] e_wd;
    #1;
    req = valid & (mem_read ^ mem_write);
    fc  = mem_write & reg_write & (wb_rd == rs);
    for (int i = 0; i < N; i++) begin
      if (pos[i] == 0) begin
        e_fwd = fc;
        e_en = req; e_we = req & mem_write; e_wd = req ? mux : 8'h00;
        e_stall[i] = req & (lat[i] > 1);
        e_ld = req & mem_read & (lat[i] == 1);
      end else begin
        e_fwd = m_fwd[i]; e_en = 1'b1; e_we = m_we[i]; e_wd = m_wd[i];
        e_stall[i] = (pos[i] < lat[i] - 1);
        e_ld = (pos[i] == lat[i] - 1) & ~m_we[i];
      end
      if (do_chk) begin
        chk($sformatf("fwd_sel[L%0d]", lat[i]), 16'(fwd_o[i]), 16'(e_fwd));
        chk($sformatf("dmem_en[L%0d]", lat[i]), 16'(en_o[i]), 16'(e_en));
        chk($sformatf("dmem_we[L%0d]", lat[i]), 16'(we_o[i]), 16'(e_we));
        chk($sformatf("dmem_wdata[L%0d]", lat[i]), 16'(wd_o[i]), 16'(e_wd));
        chk($sformatf("pipe_stall[L%0d]", lat[i]), 16'(stall_o[i]), 16'(e_stall[i]));
        chk($sformatf("load_done[L%0d]", lat[i]), 16'(ld_o[i]), 16'(e_ld));
        chk($sformatf("proto_err[L%0d]", lat[i]), 16'(err_o[i]), 16'(m_err[i]));
        chk($sformatf("stall_count[L%0d]", lat[i]), sc_o[i], 16'(m_sc[i]));
      end
    end
  endtask

  task automatic advance();
    logic req, fc;
    req = valid & (mem_read ^ mem_write);
    fc  = mem_write & reg_write & (wb_rd == rs);
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (valid & mem_read & mem_write) m_err[i] = 1'b1;
      if (e_stall[i] && m_sc[i] < 65535) m_sc[i]++;
      if (pos[i] == 0) begin
        if (req && lat[i] > 1) begin
          pos[i] = 1; m_wd[i] = mux; m_we[i] = mem_write; m_fwd[i] = fc;
        end
      end else begin
        pos[i] = (pos[i] == lat[i] - 1) ? 0 : pos[i] + 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic step(input bit do_chk);
    settle_check(do_chk);
    advance();
  endtask

  initial begin
    model_clear();
    reset_all();

    // Single-cycle store with WB forwarding.
    valid = 1; mem_write = 1; mem_read = 0; rs = 3; wb_rd = 3; reg_write = 1; mux = 8'hA5;
    settle_check(1);
    chk("t1_fwd", 16'(fwd_o[0]), 16'd1);
    chk("t1_en", 16'(en_o[0]), 16'd1);
    chk("t1_we", 16'(we_o[0]), 16'd1);
    chk("t1_wdata", 16'(wd_o[0]), 16'h00A5);
    chk("t1_stall", 16'(stall_o[0]), 16'd0);
    advance();

    // Latency-3 store: data and forwarding held while inputs move.
    valid = 0; reset_all();
    valid = 1; mem_write = 1; mem_read = 0; rs = 3; wb_rd = 3; reg_write = 1; mux = 8'h3C;
    for (int c = 0; c < 3; c++) begin
      settle_check(1);
      chk($sformatf("t2_wdata_c%0d", c), 16'(wd_o[1]), 16'h003C);
      chk($sformatf("t2_fwd_c%0d", c), 16'(fwd_o[1]), 16'd1);
      chk($sformatf("t2_stall_c%0d", c), 16'(stall_o[1]), (c < 2) ? 16'd1 : 16'd0);
      advance();
      mux = 8'h00; reg_write = 0;
    end
    valid = 0;
    settle_check(1);
    chk("t2_stall_count", sc_o[1], 16'd2);
    advance();

    // Back-to-back load then store at latency 3.
    reset_all();
    valid = 1; mem_read = 1; mem_write = 0; mux = 8'h11;
    for (int c = 0; c < 3; c++) begin
      settle_check(1);
      chk($sformatf("t3_ld_c%0d", c), 16'(ld_o[1]), (c == 2) ? 16'd1 : 16'd0);
      advance();
    end
    mem_read = 0; mem_write = 1; mux = 8'h77;
    settle_check(1);
    chk("t3_st_en", 16'(en_o[1]), 16'd1);
    chk("t3_st_we", 16'(we_o[1]), 16'd1);
    chk("t3_st_stall", 16'(stall_o[1]), 16'd1);
    advance();
    valid = 0;
    repeat (3) step(1);

    // Read+write conflict then legal traffic; error stays sticky.
    reset_all();
    valid = 1; mem_read = 1; mem_write = 1;
    settle_check(1);
    chk("t4_en", 16'(en_o[1]), 16'd0);
    chk("t4_stall", 16'(stall_o[1]), 16'd0);
    chk("t4_err_before", 16'(err_o[1]), 16'd0);
    advance();
    valid = 0;
    settle_check(1);
    chk("t4_err_set", 16'(err_o[1]), 16'd1);
    advance();
    for (int k = 0; k < 10; k++) begin
      valid = 1; mem_read = k[0]; mem_write = ~k[0]; mux = 8'($urandom);
      repeat (3) step(1);
    end
    valid = 0;
    settle_check(1);
    chk("t4_err_held", 16'(err_o[1]), 16'd1);
    advance();

    // Reset during the WAIT state at latency 4, then a clean load.
    reset_all();
    valid = 1; mem_read = 1; mem_write = 0;
    step(1);
    reset_all();
    for (int c = 0; c < 4; c++) begin
      settle_check(1);
      chk($sformatf("t5_ld_c%0d", c), 16'(ld_o[2]), (c == 3) ? 16'd1 : 16'd0);
      advance();
    end

    // Stall counter saturation.
    valid = 0; reset_all();
    valid = 1; mem_read = 1; mem_write = 0;
    repeat (75000) step(0);
    settle_check(1);
    chk("t6_sat", sc_o[3], 16'hFFFF);
    advance();

    // Randomized traffic against the model.
    valid = 0; reset_all();
    repeat (1500) begin
      int mode;
      valid = ($urandom_range(0, 3) != 0);
      mode = $urandom_range(0, 15);
      mem_read  = (mode == 0) || (mode >= 1 && mode <= 7);
      mem_write = (mode == 0) || (mode >= 8 && mode <= 14);
      rs = 3'($urandom_range(0, 3));
      wb_rd = 3'($urandom_range(0, 3));
      reg_write = $urandom_range(0, 1);
      mux = 8'($urandom);
      step(1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
